seven_seg_scan_driver: RTL

- Downstream display stage for the counter/debouncer block.
- Takes a 32-bit value (8 hex nibbles) and time-multiplexes it across the 8-digit common-anode 7-segment display of the board.
- Owns the refresh prescaler, digit scan counter, tear-free frame shadowing and hex-to-segment decode.
- Its `segments`/`anodos` outputs drive {CA..CG} and AN directly.

---
 rtl/seven_seg_scan_driver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with per-frame value shadowing.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seven_seg_scan_driver #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int REFRESH_HZ  = 1_000,
  parameter int N_DIGITS    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  output logic [6:0]  segments,
  output logic [7:0]  anodos,
  output logic        frame_start
);

  localparam int DIV = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(N_DIGITS - 1);
  localparam logic [7:0]    DIGIT_MASK = 8'((1 << N_DIGITS) - 1);

  if (DIV < 2) begin : g_div_chk
    $error("seven_seg_scan_driver: CLK_FREQ_HZ/REFRESH_HZ must be at least 2");
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_ndig_chk
    $error("seven_seg_scan_driver: N_DIGITS must be in 1..8");
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Position of the highest nonzero nibble; 0 when the whole value is zero.
  function automatic logic [2:0] msnz_pos(input logic [31:0] v);
    logic [2:0] pos;
    pos = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) pos = 3'(i);
    end
    return pos;
  endfunction

  logic [2:0] msnz_q, msnz_d;
`endif

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   value_sh_q, value_sh_d;
  logic [7:0]    en_sh_q, en_sh_d;
  logic [7:0]    anodos_q, anodos_d;
  logic [6:0]    segments_q, segments_d;
  logic          frame_start_q, frame_start_d;

  logic       tick;
  logic       frame_cap;
  logic       lit;
  logic [3:0] nibble;

  always_comb begin
    tick          = (prescaler_q == PRE_LAST);
    frame_cap     = tick && (idx_q == IDX_LAST);
    prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
    idx_d         = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    value_sh_d    = frame_cap ? value : value_sh_q;
    en_sh_d       = frame_cap ? digit_en : en_sh_q;
    frame_start_d = frame_cap;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    msnz_d        = frame_cap ? msnz_pos(value) : msnz_q;
    lit           = en_sh_q[idx_q] && (idx_q <= msnz_q);
`else
    lit           = en_sh_q[idx_q];
`endif
    // Output stage shows the digit selected by the current index, one cycle later.
    nibble        = value_sh_q[{idx_q, 2'b00} +: 4];
    anodos_d      = 8'hFF;
    segments_d    = 7'h7F;
    if (lit) begin
      anodos_d   = ~((8'h01 << idx_q) & DIGIT_MASK);
      segments_d = hex_to_seg(nibble);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler_q   <= '0;
      idx_q         <= 3'd0;
      value_sh_q    <= 32'h0;
      en_sh_q       <= 8'hFF;
      anodos_q      <= 8'hFF;
      segments_q    <= 7'h7F;
      frame_start_q <= 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      msnz_q        <= 3'd0;
`endif
    end else begin
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      value_sh_q    <= value_sh_d;
      en_sh_q       <= en_sh_d;
      anodos_q      <= anodos_d;
      segments_q    <= segments_d;
      frame_start_q <= frame_start_d;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      msnz_q        <= msnz_d;
`endif
    end
  end

  assign anodos      = anodos_q;
  assign segments    = segments_q;
  assign frame_start = frame_start_q;

endmodule
